// File: rtl/bdiv36by18_seq.sv
// Sequential unsigned restoring divider: N_W-bit dividend / D_W-bit divisor,
// one quotient bit per cycle, valid/ready on both sides, single op in flight.
module bdiv36by18_seq #(
   parameter int N_W = 36,
   parameter int D_W = 18
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] N,
   input  logic [D_W-1:0] D,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N_W-1:0] Q,
   output logic [D_W-1:0] R,
   output logic           dz
);

   localparam int C_W = $clog2(N_W);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state, state_nxt;
   logic [N_W-1:0] qsh;
   logic [D_W:0]   prem;
   logic [D_W-1:0] div;
   logic [C_W-1:0] count;

   logic [D_W+1:0] shifted;
   logic [D_W+1:0] trial;
   logic           q_bit;
   logic [D_W:0]   prem_nxt;
   logic [N_W-1:0] qsh_nxt;
   logic           last;

   // prem stays below div, so the top bit of shifted is always 0; it is kept
   // only so the subtraction borrow lands in trial's MSB.
   always_comb begin
      shifted  = {prem, qsh[N_W-1]};
      trial    = shifted - {2'b00, div};
      q_bit    = ~trial[D_W+1];
      prem_nxt = q_bit ? trial[D_W:0] : shifted[D_W:0];
      qsh_nxt  = {qsh[N_W-2:0], q_bit};
      last     = (count == C_W'(N_W - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: if (last) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qsh   <= '0;
         prem  <= '0;
         div   <= '0;
         count <= '0;
         Q     <= '0;
         R     <= '0;
         dz    <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         qsh   <= N;
         div   <= D;
         prem  <= '0;
         count <= '0;
         dz    <= (D == '0);
      end else if (state == BUSY) begin
         qsh   <= qsh_nxt;
         prem  <= prem_nxt;
         count <= count + C_W'(1);
         // Result registers change only here so they hold steady through DONE.
         if (last) begin
            Q <= dz ? '1 : qsh_nxt;
            R <= dz ? '0 : prem_nxt[D_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_bdiv36by18_seq.sv
// Scoreboard bench for bdiv36by18_seq: directed vectors plus a short random
// run with output stalls; a negedge monitor checks results and latency.
module tb_bdiv36by18_seq;

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, dz;
   logic [35:0] N, Q;
   logic [17:0] D, R;

   bdiv36by18_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .N(N), .D(D), .out_valid(out_valid), .out_ready(out_ready),
      .Q(Q), .R(R), .dz(dz)
   );

   typedef struct {
      logic [35:0] q;
      logic [17:0] r;
      logic        z;
      logic [35:0] n;
      logic [17:0] d;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic ov_q     = 1'b0;
   logic rnd_on   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got stuck, required completion");
      $fatal(1, "watchdog");
   end

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: sampled at negedge so a handshake seen here completes on the next posedge.
   always @(negedge clk) begin
      exp_t e;
      logic [63:0] recon;
      if (rst_n) begin
         if (out_valid && !ov_q) begin
            if (sb.size() == 0) check("unexpected_out_valid", 64'd1, 64'd0);
            else                check("latency", 64'(cyc - sb[0].acc), 64'd36);
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("Q", 64'(Q), 64'(e.q));
            check("R", 64'(R), 64'(e.r));
            check("dz", 64'(dz), 64'(e.z));
            if (e.d != 0) begin
               recon = 64'(Q) * 64'(D_of(e)) + 64'(R);
               check("identity_N", recon, 64'(e.n));
               check("R_lt_D", 64'(R < e.d), 64'd1);
            end
         end
      end
      ov_q = out_valid && rst_n;
   end

   function automatic logic [17:0] D_of(exp_t e);
      return e.d;
   endfunction

   // Drive operands at posedge+1 and hold until in_ready is seen at a negedge.
   task automatic issue(input logic [35:0] n, input logic [17:0] d,
                        input logic [35:0] q, input logic [17:0] r, input logic z);
      exp_t e;
      logic got;
      got = 1'b0;
      N = n; D = d; in_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (in_ready) begin got = 1'b1; break; end
      end
      if (!got) check("accept_timeout", 64'd0, 64'd1);
      else begin
         e.q = q; e.r = r; e.z = z; e.n = n; e.d = d; e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   initial begin
      logic [63:0] tmp;
      logic [35:0] rn;
      logic [17:0] rd;
      rst_n = 1'b0; in_valid = 1'b0; N = '0; D = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_Q", 64'(Q), 64'd0);
      check("rst_R", 64'(R), 64'd0);
      check("rst_dz", 64'(dz), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic op; in_ready must stay low mid-operation
      issue(36'd1000, 18'd7, 36'd142, 18'd6, 1'b0);
      repeat (20) @(negedge clk);
      check("busy_in_ready", 64'(in_ready), 64'd0);
      check("busy_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      drain();

      // extremes, divide-by-zero, N<D, back to back
      issue(36'hF_FFFF_FFFF, 18'h3FFFF, 36'd262145, 18'd0, 1'b0);
      issue(36'hF_FFFF_FFFF, 18'd1, 36'hF_FFFF_FFFF, 18'd0, 1'b0);
      issue(36'd12345, 18'd0, 36'hF_FFFF_FFFF, 18'd0, 1'b1);
      issue(36'd10, 18'd3, 36'd3, 18'd1, 1'b0);
      issue(36'd5, 18'd9, 36'd0, 18'd5, 1'b0);
      issue(36'd0, 18'd9, 36'd0, 18'd0, 1'b0);
      drain();

      // backpressure: result held, new operands refused while DONE
      out_ready = 1'b0;
      issue(36'd123456789, 18'd1000, 36'd123456, 18'd789, 1'b0);
      for (int i = 0; i < 80; i++) begin
         if (out_valid) break;
         @(posedge clk); #1;
      end
      check("bp_out_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         tmp = {$urandom, $urandom};
         N = tmp[35:0]; D = tmp[53:36]; in_valid = 1'b1;
         @(negedge clk);
         check("bp_Q_hold", 64'(Q), 64'd123456);
         check("bp_R_hold", 64'(R), 64'd789);
         check("bp_dz_hold", 64'(dz), 64'd0);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      N = 36'd200; D = 18'd7;
      @(negedge clk);
      check("no_bypass_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      issue(36'd200, 18'd7, 36'd28, 18'd4, 1'b0);
      drain();

      // reset mid-BUSY at count 17: everything returns to reset values
      issue(36'd777, 18'd5, 36'd155, 18'd2, 1'b0);
      repeat (17) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_Q", 64'(Q), 64'd0);
      check("midrst_R", 64'(R), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(36'd99, 18'd10, 36'd9, 18'd9, 1'b0);
      drain();

      // random ops with random output stalls
      rnd_on = 1'b1;
      fork
         begin
            for (int k = 0; k < 200; k++) begin
               tmp = {$urandom, $urandom};
               rn = (k % 5 == 0) ? 36'($urandom_range(0, 5000)) : tmp[35:0];
               if (k % 17 == 0)     rd = 18'd0;
               else if (k % 4 == 0) rd = 18'($urandom_range(1, 15));
               else                 rd = 18'($urandom);
               if (rd == 0) issue(rn, rd, 36'hF_FFFF_FFFF, 18'd0, 1'b1);
               else         issue(rn, rd, 36'(64'(rn) / 64'(rd)), 18'(64'(rn) % 64'(rd)), 1'b0);
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
